neural_simd_pipe: RTL

- Parametrised, pipelined successor to the neural_simd pixel/activation SIMD unit.
- Processes LANES independent unsigned lanes of LW bits per beat.
- Adds an 8-op mode set, valid/ready handshaking on both sides, per-lane saturation flags and a fixed 2-cycle pipeline.
- Sits between the register-file read port and the writeback/stream sink of the neural coprocessor.

---
 rtl/neural_simd_pkg.sv | 27 ++
 rtl/neural_simd_lane.sv | 104 ++++++++++
 rtl/neural_simd_pipe.sv | 69 ++++++
 3 files changed

// File: rtl/neural_simd_pkg.sv
// rtl/neural_simd_pkg.sv - mode encodings and lane-extraction helper shared by neural_simd_pipe
package neural_simd_pkg;

    localparam logic [2:0] MODE_BLEND = 3'b000;
    localparam logic [2:0] MODE_INV   = 3'b001;
    localparam logic [2:0] MODE_ADDS  = 3'b010;
    localparam logic [2:0] MODE_SUBS  = 3'b011;
    localparam logic [2:0] MODE_MAX   = 3'b100;
    localparam logic [2:0] MODE_MIN   = 3'b101;
    localparam logic [2:0] MODE_THR   = 3'b110;
    localparam logic [2:0] MODE_ABSD  = 3'b111;

    localparam int MAX_LW  = 32;
    localparam int MAX_VEC = 1024;

    // Returns lane idx of a packed vector, zero-extended to MAX_LW bits.
    function automatic logic [MAX_LW-1:0] lane_get(input logic [MAX_VEC-1:0] vec,
                                                   input int unsigned idx,
                                                   input int unsigned lw);
        logic [MAX_VEC-1:0] shifted;
        logic [MAX_LW-1:0]  mask;
        shifted = vec >> (idx * lw);
        mask    = {MAX_LW{1'b1}} >> (MAX_LW - lw);
        return shifted[MAX_LW-1:0] & mask;
    endfunction

endpackage

// File: rtl/neural_simd_lane.sv
// rtl/neural_simd_lane.sv - one LW-bit lane, two-stage datapath; NEURAL_SIMD_ROUND_EN selects round-half-up blend
module neural_simd_lane
    import neural_simd_pkg::*;
#(
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s1_en,
    input  logic          s2_en,
    input  logic [2:0]    mode,
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic [LW-1:0] p,
    output logic [LW-1:0] rd,
    output logic          sat
);

    localparam logic [2*LW:0] ONE_X  = {{LW{1'b0}}, 1'b1, {LW{1'b0}}};
    localparam logic [2*LW:0] HALF_X = {{(LW+1){1'b0}}, 1'b1, {(LW-1){1'b0}}};

    logic [2*LW:0] a_x, b_x, p_x, ip_x, acc_n;
    logic [LW:0]   sum_n, diff_n;

    logic [2*LW:0] acc_q;
    logic [LW:0]   sum_q, diff_q;
    logic [LW-1:0] a_q, b_q;
    logic          ge_ab_q, ge_ap_q;
    logic [2:0]    mode_q;

    logic [2*LW:0] blend_r;
    logic [LW-1:0] res;
    logic          res_sat;

    // Stage 1: products, widened add/sub (top bit = carry/borrow) and compares
    assign a_x    = {{(LW+1){1'b0}}, a};
    assign b_x    = {{(LW+1){1'b0}}, b};
    assign p_x    = {{(LW+1){1'b0}}, p};
    assign ip_x   = ONE_X - p_x;
    assign acc_n  = a_x * ip_x + b_x * p_x;
    assign sum_n  = {1'b0, a} + {1'b0, p};
    assign diff_n = {1'b0, a} - {1'b0, p};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            sum_q   <= '0;
            diff_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ge_ab_q <= 1'b0;
            ge_ap_q <= 1'b0;
            mode_q  <= MODE_BLEND;
        end else if (s1_en) begin
            acc_q   <= acc_n;
            sum_q   <= sum_n;
            diff_q  <= diff_n;
            a_q     <= a;
            b_q     <= b;
            ge_ab_q <= (a >= b);
            ge_ap_q <= (a >= p);
            mode_q  <= mode;
        end
    end

    // Stage 2: shift, clamp and select
    always_comb begin
        res     = '0;
        res_sat = 1'b0;
`ifdef NEURAL_SIMD_ROUND_EN
        blend_r = acc_q + HALF_X;
`else
        blend_r = acc_q;
`endif
        case (mode_q)
            MODE_BLEND: res = blend_r[2*LW-1:LW];
            MODE_INV:   res = ~a_q;
            MODE_ADDS: begin
                res     = sum_q[LW] ? {LW{1'b1}} : sum_q[LW-1:0];
                res_sat = sum_q[LW];
            end
            MODE_SUBS: begin
                res     = diff_q[LW] ? {LW{1'b0}} : diff_q[LW-1:0];
                res_sat = diff_q[LW];
            end
            MODE_MAX:   res = ge_ab_q ? a_q : b_q;
            MODE_MIN:   res = ge_ab_q ? b_q : a_q;
            MODE_THR:   res = ge_ap_q ? {LW{1'b1}} : {LW{1'b0}};
            MODE_ABSD:  res = ge_ab_q ? (a_q - b_q) : (b_q - a_q);
            default:    res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd  <= '0;
            sat <= 1'b0;
        end else if (s2_en) begin
            rd  <= res;
            sat <= res_sat;
        end
    end

endmodule

// File: rtl/neural_simd_pipe.sv
// rtl/neural_simd_pipe.sv - LANES x LW SIMD unit, 2-cycle valid/ready pipeline; blend rounding via NEURAL_SIMD_ROUND_EN
module neural_simd_pipe
    import neural_simd_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          mode,
    input  logic [LANES*LW-1:0] rs1,
    input  logic [LANES*LW-1:0] rs2,
    input  logic [LANES*LW-1:0] param,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*LW-1:0] rd,
    output logic [LANES-1:0]    out_sat
);

    logic s1_valid, s2_valid;
    logic s1_advance;
    logic s1_en, s2_en;

    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_valid  = s2_valid;

    // Data registers only load on a real beat so a stalled or idle output holds its last value
    assign s1_en = in_valid && in_ready;
    assign s2_en = s1_valid && s1_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_advance) begin
                s2_valid <= s1_valid;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LW-1:0] a_i, b_i, p_i;

        assign a_i = LW'(lane_get(MAX_VEC'(rs1), i, LW));
        assign b_i = LW'(lane_get(MAX_VEC'(rs2), i, LW));
        assign p_i = LW'(lane_get(MAX_VEC'(param), i, LW));

        neural_simd_lane #(.LW(LW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .s1_en (s1_en),
            .s2_en (s2_en),
            .mode  (mode),
            .a     (a_i),
            .b     (b_i),
            .p     (p_i),
            .rd    (rd[i*LW +: LW]),
            .sat   (out_sat[i])
        );
    end

endmodule
